mem_access_master: RTL and testbench

MEM_ACCESS_MASTER -- requirements
Module: mem_access_master

---
 rtl/mem_access_master_if.sv | 40 ++++
 rtl/mem_access_master.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_master.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_master_if.sv
// Request/response bus plus RAM port of the memory access master.
// master modport: the access block (takes requests, drives the RAM port).
// slave modport: the requester and RAM model side.
interface mem_access_master_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    // response channel
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    // RAM port
    logic [63:0] ram_raddr;
    logic [63:0] ram_rdata;
    logic [63:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wstrb;
    logic        ram_wen;

    modport master (
        input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output ram_raddr, ram_waddr, ram_wdata, ram_wstrb, ram_wen,
        input  ram_rdata
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  ram_raddr, ram_waddr, ram_wdata, ram_wstrb, ram_wen,
        output ram_rdata
    );
endinterface

// File: rtl/mem_access_master.sv
// Single-outstanding load/store master onto a 64-bit fixed-latency RAM.
// Latency accept->resp_valid: load READ_LATENCY+2, store 2, misaligned 1.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
// Ports: clock, reset (sync, active-high); bus = request, response and RAM
// port signals grouped in mem_access_master_if (master side).
module mem_access_master #(
    parameter int READ_LATENCY = 1  // legal 1..7
) (
    input logic                  clock,
    input logic                  reset,
    mem_access_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        wen_q;
    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [63:0] wdata_q;
    logic [2:0]  cnt_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic [2:0]  req_lo_mask;
    logic        req_misaligned;
    logic        rd_done;
    logic [63:0] rd_shifted;
    logic [63:0] rd_ext;
    logic [7:0]  size_strb;

    assign accept = bus.req_valid && (state == IDLE);

    // Alignment only depends on the low three address bits; a size-n access
    // is aligned when the low n bits are zero.
    always_comb begin
        req_lo_mask = 3'b000;
        case (bus.req_size)
            2'd0:    req_lo_mask = 3'b000;
            2'd1:    req_lo_mask = 3'b001;
            2'd2:    req_lo_mask = 3'b011;
            default: req_lo_mask = 3'b111;
        endcase
    end

    assign req_misaligned = (bus.req_addr[2:0] & req_lo_mask) != 3'b000;

    // Address goes out on entry to RD; the RAM needs READ_LATENCY edges after
    // that, so the data is taken on the edge after the counter reaches it.
    assign rd_done = (cnt_q == 3'(READ_LATENCY));

    assign rd_shifted = bus.ram_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        rd_ext = 64'd0;
        case (size_q)
            2'd0:    rd_ext = signed_q ? {{56{rd_shifted[7]}},  rd_shifted[7:0]}
                                       : {56'd0, rd_shifted[7:0]};
            2'd1:    rd_ext = signed_q ? {{48{rd_shifted[15]}}, rd_shifted[15:0]}
                                       : {48'd0, rd_shifted[15:0]};
            2'd2:    rd_ext = signed_q ? {{32{rd_shifted[31]}}, rd_shifted[31:0]}
                                       : {32'd0, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_comb begin
        size_strb = 8'h00;
        case (size_q)
            2'd0:    size_strb = 8'h01;
            2'd1:    size_strb = 8'h03;
            2'd2:    size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_misaligned) begin
                        state_nxt = RESP;
                    end else if (bus.req_wen) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = rd_done ? RESP : RD;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, read counter and response registers. The response
    // registers are only written on entry to RESP so they hold in between.
    always_ff @(posedge clock) begin
        if (reset) begin
            wen_q        <= 1'b0;
            addr_q       <= 64'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            wdata_q      <= 64'd0;
            cnt_q        <= 3'd0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wen_q    <= bus.req_wen;
                        addr_q   <= bus.req_addr;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        cnt_q    <= 3'd0;
                        if (req_misaligned) begin
                            resp_rdata_q <= 64'd0;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (rd_done) begin
                        resp_rdata_q <= rd_ext;
                        resp_err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                WR: begin
                    resp_rdata_q <= 64'd0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs: RAM port is only active in its own state, zero elsewhere.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;
        bus.ram_raddr  = 64'd0;
        bus.ram_waddr  = 64'd0;
        bus.ram_wdata  = 64'd0;
        bus.ram_wstrb  = 8'h00;
        bus.ram_wen    = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            RD:   bus.ram_raddr = {addr_q[63:3], 3'b000};
            WR: begin
                bus.ram_wen   = wen_q;
                bus.ram_waddr = {addr_q[63:3], 3'b000};
                bus.ram_wdata = wdata_q << {addr_q[2:0], 3'b000};
                bus.ram_wstrb = size_strb << addr_q[2:0];
            end
            default: bus.resp_valid = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: two instances (READ_LATENCY 1 and 3) share the
// stimulus and a 16-qword RAM; results are compared with a byte-level model.
// Every comparison goes through check().
module tb_mem_access_master;

    logic clock;
    logic reset;

    mem_access_master_if if1 ();
    mem_access_master_if if3 ();

    mem_access_master #(.READ_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));
    mem_access_master #(.READ_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: write port follows dut1 (dut3 issues identical writes),
    // separate read pipelines per latency.
    logic [63:0] mem     [0:15];
    logic [63:0] ref_mem [0:15];
    logic [63:0] pipe1;
    logic [63:0] pipe3 [0:2];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [63:0] pre_val;

    always @(posedge clock) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (if1.ram_wen) begin
            for (int b = 0; b < 8; b++)
                if (if1.ram_wstrb[b]) mem[if1.ram_waddr[6:3]][8*b +: 8] <= if1.ram_wdata[8*b +: 8];
        end
        pipe1    <= mem[if1.ram_raddr[6:3]];
        pipe3[0] <= mem[if3.ram_raddr[6:3]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign if1.ram_rdata = pipe1;
    assign if3.ram_rdata = pipe3[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wen, input logic [63:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
        if1.req_valid = v;   if3.req_valid = v;
        if1.req_wen = wen;   if3.req_wen = wen;
        if1.req_addr = addr; if3.req_addr = addr;
        if1.req_size = size; if3.req_size = size;
        if1.req_signed = sgn; if3.req_signed = sgn;
        if1.req_wdata = wdata; if3.req_wdata = wdata;
    endtask

    task automatic set_qword(input int idx, input logic [63:0] val);
        @(negedge clock);
        pre_en = 1'b1; pre_idx = 4'(idx); pre_val = val;
        ref_mem[idx] = val;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size, input logic sgn);
        logic [63:0] q;
        logic [63:0] mask;
        int nb;
        nb = 1 << size;
        q = ref_mem[addr[6:3]] >> (8 * int'(addr[2:0]));
        if (nb == 8) return q;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        q = q & mask;
        if (sgn && q[8*nb-1]) q = q | ~mask;
        return q;
    endfunction

    task automatic ref_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata);
        int off;
        int nb;
        off = int'(addr[2:0]);
        nb  = 1 << size;
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + nb)
                ref_mem[addr[6:3]][8*b +: 8] = wdata[8*(b-off) +: 8];
    endtask

    // One isolated request; both instances must be idle. Latencies are
    // counted in cycles after the accepting edge.
    task automatic run_req(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [63:0] wdata);
        int nb, off, exp_l1, exp_l3;
        logic mis, is_wr;
        logic [63:0] exp_rd, exp_wd, exp_wa;
        logic [7:0] exp_strb;
        int r1_cyc, r3_cyc, r1_n, r3_n, w1_n, w3_n, bad;
        logic [63:0] rd1, rd3, wa1, wd1;
        logic [7:0] ws1, ws3;
        logic e1, e3;
        nb  = 1 << size;
        off = int'(addr[2:0]);
        mis = (off % nb) != 0;
        is_wr = wen && !mis;
        exp_rd = 64'd0; exp_wd = 64'd0; exp_strb = 8'h00;
        exp_wa = {addr[63:3], 3'b000};
        if (mis) begin
            exp_l1 = 1; exp_l3 = 1;
        end else if (wen) begin
            exp_l1 = 2; exp_l3 = 2;
            exp_wd = wdata << (8 * off);
            for (int b = 0; b < 8; b++) exp_strb[b] = (b >= off && b < off + nb);
            ref_store(addr, size, wdata);
        end else begin
            exp_l1 = 3; exp_l3 = 5;
            exp_rd = ref_load(addr, size, sgn);
        end
        r1_cyc = 0; r3_cyc = 0; r1_n = 0; r3_n = 0; w1_n = 0; w3_n = 0; bad = 0;
        rd1 = 0; rd3 = 0; wa1 = 0; wd1 = 0; ws1 = 0; ws3 = 0; e1 = 0; e3 = 0;
        @(negedge clock);
        check("ready_before", {62'd0, if3.req_ready, if1.req_ready}, 64'd3);
        drive(1'b1, wen, addr, size, sgn, wdata);
        @(posedge clock);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                check("ready_busy", {62'd0, if3.req_ready, if1.req_ready}, 64'd0);
                if (!wen && !mis) begin
                    check("raddr1", if1.ram_raddr, exp_wa);
                    check("raddr3", if3.ram_raddr, exp_wa);
                end
                if1.req_valid = 1'b0; if3.req_valid = 1'b0;
            end
            if (if1.resp_valid) begin
                r1_n++;
                if (r1_cyc == 0) begin r1_cyc = cyc; rd1 = if1.resp_rdata; e1 = if1.resp_err; end
            end
            if (if3.resp_valid) begin
                r3_n++;
                if (r3_cyc == 0) begin r3_cyc = cyc; rd3 = if3.resp_rdata; e3 = if3.resp_err; end
            end
            if (if1.ram_wen) begin w1_n++; wa1 = if1.ram_waddr; wd1 = if1.ram_wdata; ws1 = if1.ram_wstrb; end
            else if (if1.ram_wstrb != 8'h00) bad++;
            if (if3.ram_wen) begin w3_n++; ws3 = if3.ram_wstrb; end
            else if (if3.ram_wstrb != 8'h00) bad++;
        end
        check("lat1", 64'(r1_cyc), 64'(exp_l1));
        check("lat3", 64'(r3_cyc), 64'(exp_l3));
        check("resp_cnt", 64'(r1_n + r3_n), 64'd2);
        check("rdata1", rd1, exp_rd);
        check("rdata3", rd3, exp_rd);
        check("err", {62'd0, e3, e1}, mis ? 64'd3 : 64'd0);
        check("wr_cnt", 64'(w1_n + w3_n), is_wr ? 64'd2 : 64'd0);
        check("strb_idle", 64'(bad), 64'd0);
        if (is_wr) begin
            check("waddr", wa1, exp_wa);
            check("wdata", wd1, exp_wd);
            check("wstrb1", {56'd0, ws1}, {56'd0, exp_strb});
            check("wstrb3", {56'd0, ws3}, {56'd0, exp_strb});
        end
        check("rdata_hold", if1.resp_rdata, exp_rd);
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [1:0]  sz;
        int acc1, acc3, rsp, wrs, badw;

        reset = 1'b1;
        pre_en = 1'b0; pre_idx = 4'd0; pre_val = 64'd0;
        drive(1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) set_qword(i, {$urandom, $urandom});
        @(negedge clock);
        check("rst_ready", {62'd0, if3.req_ready, if1.req_ready}, 64'd3);
        check("rst_resp", {61'd0, if1.resp_valid, if1.resp_err, if1.ram_wen}, 64'd0);
        check("rst_rdata", if1.resp_rdata | if3.resp_rdata, 64'd0);
        check("rst_ram", if1.ram_raddr | if1.ram_waddr | if1.ram_wdata | {56'd0, if1.ram_wstrb}, 64'd0);
        reset = 1'b0;

        // Directed cases
        set_qword(0, 64'h8765_4321_0000_0000);
        run_req(1'b0, 64'h0000_0000_8000_0004, 2'd2, 1'b1, 64'd0);
        run_req(1'b1, 64'h0000_0000_8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_00AB);
        run_req(1'b0, 64'h0000_0000_8000_0001, 2'd1, 1'b0, 64'd0);
        set_qword(0, 64'hF012_3456_789A_BCDE);
        run_req(1'b0, 64'h0000_0000_8000_0007, 2'd0, 1'b0, 64'd0);
        run_req(1'b0, 64'h0000_0000_8000_0006, 2'd1, 1'b1, 64'd0);
        run_req(1'b1, 64'h0000_0000_0000_0008, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        run_req(1'b0, 64'h0000_0000_0000_0008, 2'd3, 1'b0, 64'd0);

        // Randomized traffic, biased towards aligned accesses
        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
            wd = {$urandom, $urandom};
            run_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), wd);
        end

        // req_valid held high: one accept per IDLE visit, store double at 0x10
        wd = {$urandom, $urandom};
        acc1 = 0; acc3 = 0; rsp = 0; wrs = 0; badw = 0;
        @(negedge clock);
        drive(1'b1, 1'b1, 64'h10, 2'd3, 1'b0, wd);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clock);
            if (if1.req_valid && if1.req_ready) acc1++;
            if (if3.req_valid && if3.req_ready) acc3++;
            if (if1.resp_valid) rsp++;
            if (if1.ram_wen) begin
                wrs++;
                if (if1.ram_wstrb != 8'hFF || if1.ram_waddr != 64'h10 || if1.ram_wdata != wd) badw++;
            end
            if (k == 11) begin if1.req_valid = 1'b0; if3.req_valid = 1'b0; end
        end
        ref_store(64'h10, 2'd3, wd);
        check("b2b_acc1", 64'(acc1), 64'd4);
        check("b2b_acc3", 64'(acc3), 64'd4);
        check("b2b_resp", 64'(rsp), 64'd4);
        check("b2b_wr", 64'(wrs), 64'd4);
        check("b2b_wr_fields", 64'(badw), 64'd0);
        run_req(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);

        // Reset while in WR: the write edge still reaches the RAM, then abort
        @(negedge clock);
        drive(1'b1, 1'b1, 64'h28, 2'd2, 1'b0, 64'h1122_3344);
        @(posedge clock);
        @(negedge clock);
        check("rstwr_wen_on", {63'd0, if1.ram_wen}, 64'd1);
        if1.req_valid = 1'b0; if3.req_valid = 1'b0;
        reset = 1'b1;
        ref_store(64'h28, 2'd2, 64'h1122_3344);
        @(negedge clock);
        check("rstwr_wen_off", {62'd0, if3.ram_wen, if1.ram_wen}, 64'd0);
        reset = 1'b0;
        rsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (if1.resp_valid || if3.resp_valid) rsp++;
        end
        check("rstwr_no_resp", 64'(rsp), 64'd0);
        check("rstwr_ready", {62'd0, if3.req_ready, if1.req_ready}, 64'd3);
        run_req(1'b0, 64'h28, 2'd3, 1'b0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
